sawtooth: RTL and testbench



---
 rtl/sawtooth.sv | 111 +++++++++++
 tb/tb_sawtooth.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sawtooth.sv
// Free-running ramp generator: rising saw, falling saw or triangle with a
// rate divider and a one-cycle wrap pulse at each period boundary.
module sawtooth #(
    parameter int WIDTH        = 8,
    parameter int DIV          = 1,
    parameter int STEP_DEFAULT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             step_sel,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] waveform,
    output logic             wrap
);

    localparam logic [15:0]      DIV_LAST = 16'(DIV - 1);
    localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_waveform;
    logic             r_wrap;
    logic [15:0]      r_div_cnt;
    logic             r_dir_down;
    logic             r_was_tri;

    logic [WIDTH-1:0] w_s;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_tick;
    logic             w_is_tri;
    logic             w_tri_down;
    logic [WIDTH-1:0] w_next;
    logic             w_next_wrap;
    logic             w_next_dir_down;

    // Next ramp value, wrap flag and triangle direction for a tick
    always_comb begin
        w_s        = step_sel ? step : WIDTH'(STEP_DEFAULT);
        w_sum      = {1'b0, r_waveform} + {1'b0, w_s};
        w_diff     = {1'b0, r_waveform} - {1'b0, w_s};
        w_tick     = en && (r_div_cnt == DIV_LAST);
        w_is_tri   = (mode == 2'b10);
        // entering triangle from another mode always starts upward
        w_tri_down = r_was_tri ? r_dir_down : 1'b0;
        w_next          = w_sum[WIDTH-1:0];
        w_next_wrap     = w_sum[WIDTH];
        w_next_dir_down = r_dir_down;
        case (mode)
            2'b01: begin
                w_next      = w_diff[WIDTH-1:0];
                w_next_wrap = w_diff[WIDTH];
            end
            2'b10: begin
                if (!w_tri_down) begin
                    if (w_sum >= {1'b0, MAX_VAL}) begin
                        w_next          = MAX_VAL;
                        w_next_dir_down = 1'b1;
                    end else begin
                        w_next          = w_sum[WIDTH-1:0];
                        w_next_dir_down = 1'b0;
                    end
                    w_next_wrap = 1'b0;
                end else begin
                    // a zero step turns around at the bottom but is not a period
                    if (r_waveform <= w_s) begin
                        w_next          = {WIDTH{1'b0}};
                        w_next_dir_down = 1'b0;
                        w_next_wrap     = (w_s != {WIDTH{1'b0}});
                    end else begin
                        w_next          = w_diff[WIDTH-1:0];
                        w_next_dir_down = 1'b1;
                        w_next_wrap     = 1'b0;
                    end
                end
            end
            default: begin
                w_next      = w_sum[WIDTH-1:0];
                w_next_wrap = w_sum[WIDTH];
            end
        endcase
    end

    // Divider, ramp state and registered wrap pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_waveform <= {WIDTH{1'b0}};
            r_wrap     <= 1'b0;
            r_div_cnt  <= 16'd0;
            r_dir_down <= 1'b0;
            r_was_tri  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_tick) begin
                r_div_cnt  <= 16'd0;
                r_waveform <= w_next;
                r_wrap     <= w_next_wrap;
                r_dir_down <= w_next_dir_down;
                r_was_tri  <= w_is_tri;
            end else if (en) begin
                r_div_cnt <= r_div_cnt + 16'd1;
            end else begin
                r_div_cnt <= r_div_cnt;
            end
        end
    end

    assign waveform = r_waveform;
    assign wrap     = r_wrap;

endmodule

// File: tb/tb_sawtooth.sv
// Randomized bench for sawtooth: two instances (DIV=1 and DIV=4) share the
// stimulus and are compared every cycle against an arithmetic ramp model.
module tb_sawtooth;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       step_sel = 1'b0;
    logic [7:0] step = 8'd0;
    logic [7:0] wave_a, wave_b;
    logic       wrap_a, wrap_b;

    int n_checks = 0;
    int n_errors = 0;

    int m_val  [2];
    int m_cnt  [2];
    int m_wrap [2];
    int m_down [2];
    int m_tri  [2];
    int divs   [2] = '{1, 4};

    always #5 clk = ~clk;

    sawtooth #(.WIDTH(8), .DIV(1), .STEP_DEFAULT(1)) u_div1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .step_sel(step_sel),
        .step(step), .waveform(wave_a), .wrap(wrap_a)
    );

    sawtooth #(.WIDTH(8), .DIV(4), .STEP_DEFAULT(1)) u_div4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .step_sel(step_sel),
        .step(step), .waveform(wave_b), .wrap(wrap_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: what the spec says happens on the next edge for instance k
    task automatic model_step(input int k);
        int s, t, md;
        if (rst) begin
            m_val[k] = 0; m_cnt[k] = 0; m_wrap[k] = 0; m_down[k] = 0; m_tri[k] = 0;
        end else begin
            m_wrap[k] = 0;
            if (en) begin
                if (m_cnt[k] == divs[k] - 1) begin
                    m_cnt[k] = 0;
                    s  = step_sel ? int'(step) : 1;
                    md = (mode == 2'b11) ? 0 : int'(mode);
                    if (md == 0) begin
                        t = m_val[k] + s;
                        m_wrap[k] = (t > 255);
                        m_val[k] = t % 256;
                    end else if (md == 1) begin
                        t = m_val[k] - s;
                        m_wrap[k] = (t < 0);
                        m_val[k] = (t + 256) % 256;
                    end else begin
                        if (!m_tri[k]) m_down[k] = 0;
                        if (!m_down[k]) begin
                            if (m_val[k] + s >= 255) begin
                                m_val[k] = 255; m_down[k] = 1;
                            end else begin
                                m_val[k] = m_val[k] + s;
                            end
                        end else begin
                            if (m_val[k] <= s) begin
                                m_val[k] = 0; m_down[k] = 0; m_wrap[k] = (s != 0);
                            end else begin
                                m_val[k] = m_val[k] - s;
                            end
                        end
                    end
                    m_tri[k] = (md == 2);
                end else begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
            end
        end
    endtask

    // Apply inputs at a negedge, advance the model, then check at the next negedge
    task automatic cycle(input logic r, input logic e, input logic [1:0] md,
                         input logic ss, input logic [7:0] st);
        rst = r; en = e; mode = md; step_sel = ss; step = st;
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
        check_eq("wave_div1", 32'(wave_a), 32'(m_val[0]));
        check_eq("wrap_div1", 32'(wrap_a), 32'(m_wrap[0]));
        check_eq("wave_div4", 32'(wave_b), 32'(m_val[1]));
        check_eq("wrap_div4", 32'(wrap_b), 32'(m_wrap[1]));
    endtask

    initial begin
        int tri_exp [7] = '{100, 200, 255, 155, 55, 0, 100};
        int tri_wrap[7] = '{0, 0, 0, 0, 0, 1, 0};
        logic [7:0] v_hold;

        @(negedge clk);
        cycle(1'b1, 1'b0, 2'b00, 1'b0, 8'd0);
        cycle(1'b1, 1'b1, 2'b00, 1'b0, 8'd0);
        check_eq("reset_wave", 32'(wave_a), 32'd0);
        check_eq("reset_wrap", 32'(wrap_a), 32'd0);

        // Default rising ramp: full period of 256
        for (int i = 1; i <= 257; i++) begin
            cycle(1'b0, 1'b1, 2'b00, 1'b0, 8'd0);
            if (i == 255) begin
                check_eq("saw_top", 32'(wave_a), 32'd255);
                check_eq("saw_top_wrap", 32'(wrap_a), 32'd0);
            end
            if (i == 256) begin
                check_eq("saw_wrap_val", 32'(wave_a), 32'd0);
                check_eq("saw_wrap_pulse", 32'(wrap_a), 32'd1);
            end
        end

        // Falling saw step 3 from 0
        cycle(1'b1, 1'b0, 2'b00, 1'b0, 8'd0);
        cycle(1'b0, 1'b1, 2'b01, 1'b1, 8'd3);
        check_eq("fall_first", 32'(wave_a), 32'd253);
        check_eq("fall_borrow", 32'(wrap_a), 32'd1);
        for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, 2'b01, 1'b1, 8'd3);

        // Triangle step 100 from 0
        cycle(1'b1, 1'b0, 2'b00, 1'b0, 8'd0);
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 1'b1, 2'b10, 1'b1, 8'd100);
            check_eq("tri_val", 32'(wave_a), 32'(tri_exp[i]));
            check_eq("tri_wrap", 32'(wrap_a), 32'(tri_wrap[i]));
        end

        // Divider hold: drop en mid-count on the DIV=4 instance
        cycle(1'b1, 1'b0, 2'b00, 1'b0, 8'd0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 2'b00, 1'b0, 8'd0);
        v_hold = wave_b;
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 2'b00, 1'b0, 8'd0);
        check_eq("div_hold", 32'(wave_b), 32'(v_hold));
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 2'b00, 1'b0, 8'd0);
        check_eq("div_resume", 32'(wave_b), 32'd2);

        // Reset with a wrap pending at 0x80, en held high
        cycle(1'b1, 1'b0, 2'b00, 1'b0, 8'd0);
        cycle(1'b0, 1'b1, 2'b01, 1'b1, 8'd128);
        check_eq("pend_val", 32'(wave_a), 32'd128);
        check_eq("pend_wrap", 32'(wrap_a), 32'd1);
        cycle(1'b1, 1'b1, 2'b01, 1'b1, 8'd128);
        check_eq("rst_mid_val", 32'(wave_a), 32'd0);
        check_eq("rst_mid_wrap", 32'(wrap_a), 32'd0);
        cycle(1'b0, 1'b1, 2'b10, 1'b1, 8'd100);
        check_eq("rst_dir_up", 32'(wave_a), 32'd100);

        // Zero step in every mode: value constant, no wrap
        for (int md = 0; md < 4; md++) begin
            for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 2'(md), 1'b1, 8'd0);
            check_eq("zero_step_val", 32'(wave_a), 32'd100);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  (($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
